punc_pc_ir_cc: RTL and testbench

Architectural state block of the PUnC LC3 datapath. It holds the program counter, instruction register, N/Z/P condition codes, the LDI pointer register and a retired-instruction counter. Every register updates under the load/clear/increment strobes driven by the control FSM. Its `ir`, `n`, `z` and `p` outputs feed the control FSM directly, and the `pc` and offset outputs feed the memory and register-file address muxes.

---
 rtl/punc_pc_ir_cc.sv | 98 +++++++++
 tb/tb_punc_pc_ir_cc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/punc_pc_ir_cc.sv
// PUnC LC3 architectural state: the program counter, instruction register,
// N/Z/P condition codes, LDI pointer and a retired-instruction counter.
// Every register obeys the control-FSM strobes in every cycle. The
// PC-relative offset sums are combinational from the registered pc and ir.
module punc_pc_ir_cc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_clr,
  input  logic             pc_ld,
  input  logic             pc_inc,
  input  logic [1:0]       pc_ld_data_sel,
  input  logic             ir_ld,
  input  logic             ldi_reg_ld,
  input  logic             cond_ld,
  input  logic             cond_ld_data_sel,
  input  logic [WIDTH-1:0] mem_r_data,
  input  logic [WIDTH-1:0] rf_r0_data,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] rf_w_data,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] ldi_reg,
  output logic [WIDTH-1:0] pc_off9,
  output logic [WIDTH-1:0] pc_off11,
  output logic             n,
  output logic             z,
  output logic             p,
  output logic [WIDTH-1:0] instr_count
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cond_src;
  logic             cond_zero;

  // Branch and jump targets. Wrap-around modulo 2^WIDTH is intended.
  assign pc_off9  = pc + {{(WIDTH-9){ir[8]}},   ir[8:0]};
  assign pc_off11 = pc + {{(WIDTH-11){ir[10]}}, ir[10:0]};

  // The condition codes track either the ALU result or the value written back to the register file.
  assign cond_src  = cond_ld_data_sel ? rf_w_data : alu_out;
  assign cond_zero = (cond_src == '0);

  // PC update. Clear has the highest priority, then load, then increment.
  // Select 3 on a load is reserved, so the PC holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (pc_clr) begin
      pc <= '0;
    end else if (pc_ld) begin
      case (pc_ld_data_sel)
        2'd0:    pc <= pc_off9;
        2'd1:    pc <= rf_r0_data;
        2'd2:    pc <= pc_off11;
        default: pc <= pc;
      endcase
    end else if (pc_inc) begin
      pc <= pc + 1'b1;
    end
  end

  // IR and the LDI pointer capture memory read data independently of the PC strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      ldi_reg <= '0;
    end else begin
      if (ir_ld)      ir      <= mem_r_data;
      if (ldi_reg_ld) ldi_reg <= mem_r_data;
    end
  end

  // Condition codes are one-hot. Reset selects Z.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= 1'b0;
      z <= 1'b1;
      p <= 1'b0;
    end else if (cond_ld) begin
      n <= cond_src[WIDTH-1];
      z <= cond_zero;
      p <= ~cond_src[WIDTH-1] & ~cond_zero;
    end
  end

  // The retired-instruction count increments on each IR load and sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (ir_ld && (instr_count != ONES)) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_punc_pc_ir_cc.sv
// Directed test of the PUnC PC/IR/CC state block. It drives strobes 1 time
// unit after each rising edge and samples the outputs 1 time unit after the
// following edge.
module tb_punc_pc_ir_cc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_clr = 0, pc_ld = 0, pc_inc = 0, ir_ld = 0, ldi_reg_ld = 0;
  logic        cond_ld = 0, cond_ld_data_sel = 0;
  logic [1:0]  pc_ld_data_sel = 0;
  logic [15:0] mem_r_data = 0, rf_r0_data = 0, alu_out = 0, rf_w_data = 0;
  logic [15:0] pc, ir, ldi_reg, pc_off9, pc_off11, instr_count;
  logic        n, z, p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  punc_pc_ir_cc #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .pc_clr(pc_clr), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .pc_ld_data_sel(pc_ld_data_sel),
    .ir_ld(ir_ld), .ldi_reg_ld(ldi_reg_ld),
    .cond_ld(cond_ld), .cond_ld_data_sel(cond_ld_data_sel),
    .mem_r_data(mem_r_data), .rf_r0_data(rf_r0_data),
    .alu_out(alu_out), .rf_w_data(rf_w_data),
    .pc(pc), .ir(ir), .ldi_reg(ldi_reg),
    .pc_off9(pc_off9), .pc_off11(pc_off11),
    .n(n), .z(z), .p(p),
    .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_nzp(input string tag, input logic [2:0] exp);
    check(tag, {13'd0, n, z, p}, {13'd0, exp});
  endtask

  // Deassert every strobe.
  task automatic idle();
    pc_clr = 0; pc_ld = 0; pc_inc = 0; pc_ld_data_sel = 0;
    ir_ld = 0; ldi_reg_ld = 0; cond_ld = 0; cond_ld_data_sel = 0;
  endtask

  // Run one clock with the strobes as currently driven. Then clear them, leaving outputs ready to sample.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_ld = 1; pc_ld_data_sel = 2'd1; rf_r0_data = v;
    tick();
  endtask

  task automatic load_ir(input logic [15:0] v);
    ir_ld = 1; mem_r_data = v;
    tick();
  endtask

  initial begin
    // Reset state, with no clock edge needed.
    #1 rst = 1'b1;
    #2;
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_ldi", ldi_reg, 16'h0000);
    check("rst_cnt", instr_count, 16'h0000);
    check_nzp("rst_nzp", 3'b010);

    // Release reset. Then dirty pc, ir, cc and the counter in a single cycle.
    @(negedge clk); rst = 1'b0;
    pc_ld = 1; pc_ld_data_sel = 2'd1; rf_r0_data = 16'h1234;
    ir_ld = 1; mem_r_data = 16'hF025;
    cond_ld = 1; alu_out = 16'h8000;
    tick();
    check("pre_pc", pc, 16'h1234);
    check("pre_ir", ir, 16'hF025);
    check("pre_cnt", instr_count, 16'h0001);
    check_nzp("pre_nzp", 3'b100);

    // Assert reset asynchronously in mid-cycle.
    #2 rst = 1'b1;
    #1;
    check("arst_pc", pc, 16'h0000);
    check("arst_ir", ir, 16'h0000);
    check("arst_cnt", instr_count, 16'h0000);
    check_nzp("arst_nzp", 3'b010);

    // Release reset with pc_clr held for one cycle.
    @(negedge clk); rst = 1'b0; pc_clr = 1;
    tick();
    check("clr_pc", pc, 16'h0000);

    // The PC increment wraps.
    load_pc(16'hFFFF);
    check("ld_ffff", pc, 16'hFFFF);
    pc_inc = 1; tick();
    check("inc_wrap", pc, 16'h0000);

    // Clear beats load and increment.
    load_pc(16'h0005);
    pc_clr = 1; pc_ld = 1; pc_inc = 1; pc_ld_data_sel = 2'd1; rf_r0_data = 16'h1234;
    tick();
    check("prio_clr", pc, 16'h0000);

    // Load beats increment.
    pc_ld = 1; pc_inc = 1; pc_ld_data_sel = 2'd1; rf_r0_data = 16'h3000;
    tick();
    check("prio_ld", pc, 16'h3000);

    // A load with the reserved select holds the PC.
    load_pc(16'h0040);
    pc_ld = 1; pc_ld_data_sel = 2'd3; rf_r0_data = 16'h7777;
    tick();
    check("sel3_hold", pc, 16'h0040);

    // Offset sums.
    load_pc(16'h3001);
    load_ir(16'h0FFF);
    check("off9_m1", pc_off9, 16'h3000);
    check("off11_m1", pc_off11, 16'h3000);
    load_ir(16'h00FF);
    check("off9_p255", pc_off9, 16'h3100);
    check("off11_p255", pc_off11, 16'h3100);
    load_ir(16'h0400);
    check("off11_m1024", pc_off11, 16'h2C01);
    check("off9_zero", pc_off9, 16'h3001);
    pc_ld = 1; pc_ld_data_sel = 2'd2; tick();
    check("ld_off11", pc, 16'h2C01);
    load_pc(16'h3001);
    load_ir(16'h00FF);
    pc_ld = 1; pc_ld_data_sel = 2'd0; tick();
    check("ld_off9", pc, 16'h3100);

    // Condition codes.
    cond_ld = 1; cond_ld_data_sel = 0; alu_out = 16'h8000; rf_w_data = 16'h0001;
    tick();
    check_nzp("cc_neg", 3'b100);
    cond_ld = 1; cond_ld_data_sel = 0; alu_out = 16'h0000;
    tick();
    check_nzp("cc_zero", 3'b010);
    cond_ld = 1; cond_ld_data_sel = 1; rf_w_data = 16'h0001; alu_out = 16'h8000;
    tick();
    check_nzp("cc_pos", 3'b001);
    cond_ld = 0; alu_out = 16'h0000; rf_w_data = 16'hFFFF;
    tick();
    check_nzp("cc_hold", 3'b001);

    // IR load and PC increment in the same cycle. The ir loads so far are 1 before reset and 4 after it.
    check("cnt_before", instr_count, 16'h0004);
    ir_ld = 1; pc_inc = 1; mem_r_data = 16'hF025;
    tick();
    check("ir_f025", ir, 16'hF025);
    check("inc_with_ir", pc, 16'h3101);
    check("cnt_plus1", instr_count, 16'h0005);

    // The LDI pointer loads without touching ir.
    ldi_reg_ld = 1; mem_r_data = 16'h4000;
    tick();
    check("ldi_4000", ldi_reg, 16'h4000);
    check("ldi_ir_keep", ir, 16'hF025);
    check("ldi_cnt_keep", instr_count, 16'h0005);

    // Counter saturation: 65530 loads bring it from 5 to FFFF, then 10 more must not wrap it.
    ir_ld = 1; mem_r_data = 16'h1234;
    repeat (65530) @(posedge clk);
    #1;
    check("cnt_at_max", instr_count, 16'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    idle();
    check("cnt_sat", instr_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
